// File: rtl/vdic_mult_acc.sv
// Signed multiply / multiply-accumulate unit with even-parity argument checking,
// req/ack input handshake and a one-cycle result_rdy strobe.
module vdic_mult_acc #(
  parameter int DATA_W  = 16,
  parameter int GUARD_W = 8,
  parameter int LATENCY = 3,
  localparam int RES_W  = 2*DATA_W + GUARD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] arg_a,
  input  logic              arg_a_parity,
  input  logic [DATA_W-1:0] arg_b,
  input  logic              arg_b_parity,
  input  logic [1:0]        op,
  input  logic              req,
  output logic              ack,
  output logic [RES_W-1:0]  result,
  output logic              result_parity,
  output logic              result_rdy,
  output logic              arg_parity_error,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MAC = 2'b01, OP_CLR = 2'b10, OP_READ = 2'b11} op_t;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 2);

  state_t             state, state_next;
  logic               accept;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  a_q, b_q;
  logic               a_par_q, b_par_q;
  op_t                op_q;
  logic [RES_W-1:0]   acc;

  logic [2*DATA_W-1:0] a_ext, b_ext, prod;
  logic [RES_W-1:0]    prod_ext, sum;
  logic                mac_ovf, par_err;
  logic [RES_W-1:0]    res_next, acc_next;
  logic                ovf_next;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (req) begin
        accept     = 1'b1;
        state_next = CALC;
      end
      CALC: if (cnt == CNT_LAST) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sign-extended operands multiplied modulo 2^(2*DATA_W) give the exact signed product.
  assign a_ext    = {{DATA_W{a_q[DATA_W-1]}}, a_q};
  assign b_ext    = {{DATA_W{b_q[DATA_W-1]}}, b_q};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{GUARD_W{prod[2*DATA_W-1]}}, prod};
  assign sum      = acc + prod_ext;
  assign mac_ovf  = (acc[RES_W-1] == prod_ext[RES_W-1]) && (sum[RES_W-1] != acc[RES_W-1]);
  assign par_err  = (a_par_q != ^a_q) || (b_par_q != ^b_q);

  always_comb begin
    res_next = '0;
    ovf_next = 1'b0;
    acc_next = acc;
    if (!par_err) begin
      case (op_q)
        OP_MUL:  res_next = prod_ext;
        OP_MAC: begin
          acc_next = sum;
          res_next = sum;
          ovf_next = mac_ovf;
        end
        OP_CLR:  acc_next = '0;
        OP_READ: res_next = acc;
        default: res_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt              <= '0;
      a_q              <= '0;
      b_q              <= '0;
      a_par_q          <= 1'b0;
      b_par_q          <= 1'b0;
      op_q             <= OP_MUL;
      acc              <= '0;
      ack              <= 1'b0;
      result           <= '0;
      result_parity    <= 1'b0;
      result_rdy       <= 1'b0;
      arg_parity_error <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      ack        <= accept;
      result_rdy <= (state == DONE);
      if (state == CALC) cnt <= cnt + 1'b1;
      else               cnt <= '0;
      if (accept) begin
        a_q     <= arg_a;
        b_q     <= arg_b;
        a_par_q <= arg_a_parity;
        b_par_q <= arg_b_parity;
        op_q    <= op_t'(op);
      end
      if (state == DONE) begin
        result           <= res_next;
        result_parity    <= ^res_next;
        arg_parity_error <= par_err;
        overflow         <= ovf_next;
        acc              <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_vdic_mult_acc.sv
// Directed self-checking bench for vdic_mult_acc (DATA_W=16, GUARD_W=8, LATENCY=3).
module tb_vdic_mult_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] arg_a, arg_b;
  logic        arg_a_parity, arg_b_parity;
  logic [1:0]  op;
  logic        req;
  logic        ack;
  logic [39:0] result;
  logic        result_parity, result_rdy, arg_parity_error, overflow;

  int n_checks = 0;
  int n_pass   = 0;

  vdic_mult_acc #(.DATA_W(16), .GUARD_W(8), .LATENCY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .arg_a(arg_a), .arg_a_parity(arg_a_parity),
    .arg_b(arg_b), .arg_b_parity(arg_b_parity),
    .op(op), .req(req), .ack(ack),
    .result(result), .result_parity(result_parity), .result_rdy(result_rdy),
    .arg_parity_error(arg_parity_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Issues one request, drops req after the accept edge, returns just after the result_rdy edge.
  task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic ap,
                        input logic [15:0] b, input logic bp);
    bit seen;
    seen = 0;
    @(negedge clk);
    op = o; arg_a = a; arg_a_parity = ap; arg_b = b; arg_b_parity = bp; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (result_rdy) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL run_op_timeout: result_rdy=0 after 20 cycles, required 1");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; op = 2'b00;
    arg_a = '0; arg_b = '0; arg_a_parity = 1'b0; arg_b_parity = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ack, result_rdy, result_parity, arg_parity_error, overflow, result} !== 45'd0)
      $display("FAIL reset_outputs: got ack=%b rdy=%b par=%b perr=%b ovf=%b res=%h, required all 0",
               ack, result_rdy, result_parity, arg_parity_error, overflow, result);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int rdy_edge;
    rdy_edge = -1;
    @(negedge clk);
    op = 2'b00; arg_a = 16'hFFFE; arg_a_parity = 1'b1; arg_b = 16'h0003; arg_b_parity = 1'b0;
    req = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ack !== 1'b1) $display("FAIL mul_ack: got %b, required 1", ack);
    else n_pass++;
    @(negedge clk); req = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        n_checks++;
        if (ack !== 1'b0) $display("FAIL mul_ack_width: got %b, required 0", ack);
        else n_pass++;
      end
      if (result_rdy && rdy_edge < 0) rdy_edge = e;
    end
    n_checks++;
    if (rdy_edge != 3) $display("FAIL mul_latency: result_rdy at edge %0d, required 3", rdy_edge);
    else n_pass++;
    n_checks++;
    if (result !== 40'hFFFFFFFFFA || result_parity !== 1'b0 || arg_parity_error !== 1'b0)
      $display("FAIL mul_result: got res=%h par=%b perr=%b, required FFFFFFFFFA/0/0",
               result, result_parity, arg_parity_error);
    else n_pass++;
    run_op(2'b00, 16'h8000, 1'b1, 16'h8000, 1'b1);
    n_checks++;
    if (result !== 40'h0040000000 || result_parity !== 1'b1)
      $display("FAIL mul_min_min: got res=%h par=%b, required 0040000000/1", result, result_parity);
    else n_pass++;
  endtask

  task automatic test_parity_error();
    run_op(2'b10, 16'h0000, 1'b0, 16'h0000, 1'b0);
    run_op(2'b01, 16'h0002, 1'b1, 16'h0003, 1'b0);
    n_checks++;
    if (result !== 40'd6 || overflow !== 1'b0)
      $display("FAIL mac_small: got res=%h ovf=%b, required 6/0", result, overflow);
    else n_pass++;
    run_op(2'b01, 16'h0001, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (arg_parity_error !== 1'b1 || result !== 40'd0 || overflow !== 1'b0)
      $display("FAIL parity_mac: got perr=%b res=%h ovf=%b, required 1/0/0",
               arg_parity_error, result, overflow);
    else n_pass++;
    run_op(2'b10, 16'h0000, 1'b0, 16'h0001, 1'b0);
    n_checks++;
    if (arg_parity_error !== 1'b1)
      $display("FAIL parity_clr: got perr=%b, required 1", arg_parity_error);
    else n_pass++;
    run_op(2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (result !== 40'd6 || arg_parity_error !== 1'b0)
      $display("FAIL parity_read: got res=%h perr=%b, required 6/0", result, arg_parity_error);
    else n_pass++;
  endtask

  task automatic test_mac_overflow();
    run_op(2'b10, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 511; i++) run_op(2'b01, 16'h8000, 1'b1, 16'h8000, 1'b1);
    n_checks++;
    if (result !== 40'h7FC0000000 || overflow !== 1'b0)
      $display("FAIL mac_511: got res=%h ovf=%b, required 7FC0000000/0", result, overflow);
    else n_pass++;
    run_op(2'b01, 16'h8000, 1'b1, 16'h8000, 1'b1);
    n_checks++;
    if (result !== 40'h8000000000 || overflow !== 1'b1 || result_parity !== 1'b1)
      $display("FAIL mac_512: got res=%h ovf=%b par=%b, required 8000000000/1/1",
               result, overflow, result_parity);
    else n_pass++;
    run_op(2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (result !== 40'h8000000000 || overflow !== 1'b0)
      $display("FAIL read_after_ovf: got res=%h ovf=%b, required 8000000000/0", result, overflow);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n_ack;
    bit seen;
    n_ack = 0;
    seen = 0;
    @(negedge clk);
    op = 2'b11; arg_a = '0; arg_b = '0; arg_a_parity = 1'b0; arg_b_parity = 1'b0; req = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      if (ack) n_ack++;
      n_checks++;
      if (ack !== ((c % 4) == 1) || (ack && result_rdy))
        $display("FAIL b2b_ack_c%0d: got ack=%b rdy=%b, required ack=%b", c, ack, result_rdy,
                 (c % 4) == 1);
      else n_pass++;
    end
    @(negedge clk); req = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (result_rdy) seen = 1;
    end
    n_checks++;
    if (n_ack != 4 || !seen)
      $display("FAIL b2b_total: got acks=%0d rdy_seen=%b, required 4/1", n_ack, seen);
    else n_pass++;
  endtask

  task automatic test_busy();
    @(negedge clk);
    op = 2'b00; arg_a = 16'h0002; arg_a_parity = 1'b1; arg_b = 16'h0002; arg_b_parity = 1'b1;
    req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ack !== 1'b0) $display("FAIL busy_calc_ack: got %b, required 0", ack);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (ack !== 1'b0 || result_rdy !== 1'b1 || result !== 40'd4)
      $display("FAIL busy_done: got ack=%b rdy=%b res=%h, required 0/1/4", ack, result_rdy, result);
    else n_pass++;
    @(negedge clk); req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ack !== 1'b0 || result_rdy !== 1'b0)
      $display("FAIL busy_idle: got ack=%b rdy=%b, required 0/0", ack, result_rdy);
    else n_pass++;
  endtask

  task automatic test_reset_mid_calc();
    bit rdy_seen;
    rdy_seen = 0;
    @(negedge clk);
    op = 2'b01; arg_a = 16'h0002; arg_a_parity = 1'b1; arg_b = 16'h0003; arg_b_parity = 1'b0;
    req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); req = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (result_rdy) rdy_seen = 1;
    end
    n_checks++;
    if (rdy_seen || result !== 40'd0 || overflow !== 1'b0 || ack !== 1'b0)
      $display("FAIL reset_mid: got rdy_seen=%b res=%h ovf=%b ack=%b, required 0/0/0/0",
               rdy_seen, result, overflow, ack);
    else n_pass++;
    run_op(2'b11, 16'h0000, 1'b0, 16'h0000, 1'b0);
    n_checks++;
    if (result !== 40'd0) $display("FAIL reset_mid_read: got %h, required 0", result);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_parity_error();
    test_mac_overflow();
    test_back_to_back();
    test_busy();
    test_reset_mid_calc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
